// File: rtl/reduce_pkg.sv
// reduce_pkg: op encodings and sizing helpers shared by the reduce pipeline
package reduce_pkg;
   typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_RSV = 2'b11} op_e;
   function automatic logic identity(input logic [1:0] op);
      return op == OP_AND;
   endfunction
   function automatic int clog4(input int w);
      int l = 0;
      for (int c = 1; c < w; c = c * 4) l++;
      return l;
   endfunction
   function automatic int pipe_depth(input int w);
      return clog4(w) > 1 ? clog4(w) : 1;
   endfunction
   function automatic int level_width(input int w, input int k);
      int r = w;
      for (int i = 0; i < k; i++) r = (r + 3) / 4;
      return r;
   endfunction
   // bit offset of level k inside a bus holding every level's lanes back to back
   function automatic int level_offset(input int w, input int k);
      int s = 0;
      for (int i = 0; i < k; i++) s += level_width(w, i);
      return s;
   endfunction
endpackage

// File: rtl/reduce_stage.sv
// reduce_stage: one radix-4 reduction level with a valid/ready register slice
module reduce_stage
   import reduce_pkg::*;
#(
   parameter int IN_W = 4,
   parameter int CHANNELS = 1,
   parameter bit LAST = 1'b0,
   localparam int OUT_W = (IN_W + 3) / 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [2:0]                in_op,
   input  logic [CHANNELS*IN_W-1:0]  in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2:0]                out_op,
   output logic [CHANNELS*OUT_W-1:0] out_data
);
   logic [4*OUT_W-1:0] pad;
   logic [CHANNELS*OUT_W-1:0] red;
   logic [3:0] q;
   logic r;
   always_comb begin
      pad = '0;
      red = '0;
      q = '0;
      r = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         pad = {4*OUT_W{identity(in_op[1:0])}};
         pad[IN_W-1:0] = in_data[c*IN_W +: IN_W];
         for (int j = 0; j < OUT_W; j++) begin
            q = pad[4*j +: 4];
            r = in_op[1:0] == OP_AND ? &q : in_op[1:0] == OP_OR ? |q : ^q;
            if (LAST) r = in_op[1:0] == OP_RSV ? 1'b0 : r ^ in_op[2];
            red[c*OUT_W + j] = r;
         end
      end
   end
   assign in_ready = !out_valid || out_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_op <= '0;
         out_data <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_op <= in_op;
            out_data <= red;
         end
      end
   end
endmodule

// File: rtl/reduce_pipe.sv
// reduce_pipe: pipelined radix-4 AND/OR/XOR reduction over parallel lanes
module reduce_pipe
   import reduce_pkg::*;
#(
   parameter int INPUT_WIDTH = 8,
   parameter int CHANNELS = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [2:0]                    in_op,
   input  logic [CHANNELS*INPUT_WIDTH-1:0] in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CHANNELS-1:0]           out_data,
   output logic                          out_err
);
   localparam int LAT = pipe_depth(INPUT_WIDTH);
   localparam int BUS_W = CHANNELS * level_offset(INPUT_WIDTH, LAT + 1);
   logic rst_done;
   logic [LAT:0] vld;
   logic [LAT:0] rdy;
   logic [2:0] ops [LAT+1];
   logic [BUS_W-1:0] bus;
   // holds in_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_done <= 1'b0;
      else rst_done <= 1'b1;
   end
   assign vld[0] = in_valid && rst_done;
   assign ops[0] = in_op;
   assign bus[0 +: CHANNELS*INPUT_WIDTH] = in_data;
   assign rdy[LAT] = out_ready;
   for (genvar k = 0; k < LAT; k++) begin : g
      localparam int IW = level_width(INPUT_WIDTH, k);
      localparam int OW = level_width(INPUT_WIDTH, k + 1);
      localparam int IO = CHANNELS * level_offset(INPUT_WIDTH, k);
      localparam int OO = CHANNELS * level_offset(INPUT_WIDTH, k + 1);
      reduce_stage #(.IN_W(IW), .CHANNELS(CHANNELS), .LAST(k == LAT - 1)) u_stage (
         .clk(clk),
         .rst_n(rst_n),
         .in_valid(vld[k]),
         .in_ready(rdy[k]),
         .in_op(ops[k]),
         .in_data(bus[IO +: CHANNELS*IW]),
         .out_valid(vld[k+1]),
         .out_ready(rdy[k+1]),
         .out_op(ops[k+1]),
         .out_data(bus[OO +: CHANNELS*OW])
      );
   end
   assign in_ready = rst_done && rdy[0];
   assign out_valid = vld[LAT];
   assign out_data = bus[BUS_W-CHANNELS +: CHANNELS];
   assign out_err = vld[LAT] && (ops[LAT] inside {{1'b0, OP_RSV}, {1'b1, OP_RSV}});
endmodule

// File: tb/tb_reduce_pipe.sv
// tb_reduce_pipe: directed tables, corner sequences and a random scoreboard run
module tb_reduce_pipe;
   typedef struct {int inst; logic [2:0] o; logic [31:0] d; logic [3:0] x; logic e;} vec_t;
   typedef struct packed {logic e; logic [3:0] d;} cap_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic iv [4], ir [4], ov [4], ordy [4], oe [4];
   logic [2:0] opc [4];
   logic [31:0] id [4];
   logic [1:0] od_a;
   logic od_b, od_c;
   logic [3:0] od_d;
   int checks = 0, errors = 0;
   cap_t cap [$];
   logic [1:0] sb [$];
   vec_t tv [20];
   always #5 clk = ~clk;
   reduce_pipe #(.INPUT_WIDTH(8), .CHANNELS(2)) u_a (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
      .in_op(opc[0]), .in_data(id[0][15:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od_a), .out_err(oe[0]));
   reduce_pipe #(.INPUT_WIDTH(5), .CHANNELS(1)) u_b (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
      .in_op(opc[1]), .in_data(id[1][4:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od_b), .out_err(oe[1]));
   reduce_pipe #(.INPUT_WIDTH(17), .CHANNELS(1)) u_c (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
      .in_op(opc[2]), .in_data(id[2][16:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od_c), .out_err(oe[2]));
   reduce_pipe #(.INPUT_WIDTH(1), .CHANNELS(4)) u_d (.clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
      .in_op(opc[3]), .in_data(id[3][3:0]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od_d), .out_err(oe[3]));

   function automatic logic [3:0] get_od(input int i);
      return i == 0 ? {2'b0, od_a} : i == 1 ? {3'b0, od_b} : i == 2 ? {3'b0, od_c} : od_d;
   endfunction
   // flat reference reduction over 17 bits: returns {err, data}
   function automatic logic [1:0] ref17(input logic [2:0] o, input logic [16:0] d);
      logic r;
      if (o[1:0] == 2'b11) return 2'b10;
      r = o[1:0] == 2'b00 ? &d : o[1:0] == 2'b01 ? |d : ^d;
      return {1'b0, r ^ o[2]};
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic drive(input int i, input logic [2:0] o, input logic [31:0] d);
      opc[i] = o;
      id[i] = d;
      iv[i] = 1'b1;
      #1;
   endtask
   task automatic step(input int i);
      logic acc;
      #1;
      acc = iv[i] && ir[i];
      if (ov[i] && ordy[i]) cap.push_back(cap_t'{oe[i], get_od(i)});
      @(posedge clk);
      #1;
      if (acc) iv[i] = 1'b0;
   endtask
   task automatic one(input int k);
      int i, n;
      i = tv[k].inst;
      cap.delete();
      ordy[i] = 1'b1;
      drive(i, tv[k].o, tv[k].d);
      n = 0;
      while (cap.size() == 0 && n < 12) begin
         step(i);
         n++;
      end
      if (cap.size() == 0) chk($sformatf("vec%0d_timeout", k), 0, 1);
      else begin
         chk($sformatf("vec%0d_lat", k), n - 1, i == 3 ? 1 : 2);
         chk($sformatf("vec%0d_data", k), cap[0].d, tv[k].x);
         chk($sformatf("vec%0d_err", k), cap[0].e, tv[k].e);
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [3:0] hold;
      logic [1:0] e;
      int n, sent, recv, cyc;
      logic acc;
      tv = '{
         '{0, 3'b101, 32'h0001, 4'b0010, 1'b0}, '{0, 3'b000, 32'hFFFE, 4'b0010, 1'b0},
         '{0, 3'b001, 32'h0080, 4'b0001, 1'b0}, '{0, 3'b010, 32'h0703, 4'b0010, 1'b0},
         '{0, 3'b100, 32'hFF7F, 4'b0001, 1'b0}, '{0, 3'b110, 32'h0100, 4'b0001, 1'b0},
         '{0, 3'b011, 32'hFFFF, 4'b0000, 1'b1}, '{0, 3'b111, 32'h0000, 4'b0000, 1'b1},
         '{0, 3'b000, 32'hFFFF, 4'b0011, 1'b0}, '{0, 3'b101, 32'h0000, 4'b0011, 1'b0},
         '{1, 3'b000, 32'h001F, 4'b0001, 1'b0}, '{1, 3'b110, 32'h0016, 4'b0000, 1'b0},
         '{1, 3'b001, 32'h0010, 4'b0001, 1'b0}, '{1, 3'b000, 32'h000F, 4'b0000, 1'b0},
         '{3, 3'b000, 32'h000A, 4'b1010, 1'b0}, '{3, 3'b100, 32'h000A, 4'b0101, 1'b0},
         '{3, 3'b010, 32'h0006, 4'b0110, 1'b0}, '{3, 3'b101, 32'h0006, 4'b1001, 1'b0},
         '{3, 3'b111, 32'h000F, 4'b0000, 1'b1}, '{3, 3'b110, 32'h0003, 4'b1100, 1'b0}};
      for (int i = 0; i < 4; i++) begin
         iv[i] = 1'b0;
         ordy[i] = 1'b1;
         opc[i] = '0;
         id[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst%0d_valid", i), ov[i], 0);
         chk($sformatf("rst%0d_data", i), get_od(i), 0);
         chk($sformatf("rst%0d_err", i), oe[i], 0);
         chk($sformatf("rst%0d_ready", i), ir[i], 0);
      end
      rst_n = 1'b1;
      #1;
      chk("rel_ready_before_edge", ir[0], 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) chk($sformatf("rel%0d_ready", i), ir[i], 1);

      for (int k = 0; k < 20; k++) one(k);

      // back-to-back beats on the 5-bit instance, padding of the partial group
      cap.delete();
      drive(1, 3'b000, 32'h1F);
      step(1);
      drive(1, 3'b110, 32'h16);
      step(1);
      step(1);
      step(1);
      chk("b2b_count", cap.size(), 2);
      if (cap.size() == 2) begin
         chk("b2b_first", {cap[0].e, cap[0].d}, 5'b00001);
         chk("b2b_second", {cap[1].e, cap[1].d}, 5'b00000);
      end

      // reserved op between two OR beats
      cap.delete();
      drive(0, 3'b001, 32'h0001);
      step(0);
      drive(0, 3'b011, 32'hFFFF);
      step(0);
      drive(0, 3'b001, 32'h0300);
      step(0);
      step(0);
      step(0);
      chk("rsv_count", cap.size(), 3);
      if (cap.size() == 3) begin
         chk("rsv_before", {cap[0].e, cap[0].d}, 5'b00001);
         chk("rsv_mid", {cap[1].e, cap[1].d}, 5'b10000);
         chk("rsv_after", {cap[2].e, cap[2].d}, 5'b00010);
      end

      // backpressure: pipeline fills with LAT beats, then drains in order
      cap.delete();
      ordy[0] = 1'b0;
      drive(0, 3'b001, 32'h0100);
      chk("bp_ready0", ir[0], 1);
      step(0);
      drive(0, 3'b000, 32'hFFFF);
      chk("bp_ready1", ir[0], 1);
      step(0);
      drive(0, 3'b010, 32'h0001);
      chk("bp_full", ir[0], 0);
      step(0);
      hold = get_od(0);
      chk("bp_head", hold, 4'b0010);
      for (int k = 0; k < 5; k++) begin
         chk("bp_hold", {oe[0], ov[0], get_od(0)}, {2'b01, hold});
         step(0);
      end
      ordy[0] = 1'b1;
      n = 0;
      while (cap.size() < 3 && n < 20) begin
         step(0);
         n++;
      end
      chk("bp_count", cap.size(), 3);
      if (cap.size() == 3) begin
         chk("bp_beat0", {cap[0].e, cap[0].d}, 5'b00010);
         chk("bp_beat1", {cap[1].e, cap[1].d}, 5'b00011);
         chk("bp_beat2", {cap[2].e, cap[2].d}, 5'b00001);
      end
      step(0);
      chk("bp_no_dup", cap.size(), 3);

      // reset with two beats in flight
      ordy[0] = 1'b0;
      drive(0, 3'b000, 32'hFFFF);
      step(0);
      drive(0, 3'b001, 32'h0001);
      step(0);
      chk("flight_valid", ov[0], 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", ov[0], 0);
      chk("mid_rst_ready", ir[0], 0);
      chk("mid_rst_data", get_od(0), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("mid_rel_ready0", ir[0], 0);
      @(posedge clk);
      #1;
      chk("mid_rel_ready1", ir[0], 1);
      ordy[0] = 1'b1;
      cap.delete();
      repeat (6) step(0);
      chk("mid_rst_stale", cap.size(), 0);

      // random handshakes on the 17-bit instance against a flat reference
      sb.delete();
      sent = 0;
      recv = 0;
      cyc = 0;
      iv[2] = 1'b0;
      ordy[2] = 1'b0;
      #1;
      while (recv < 10000 && cyc < 60000) begin
         acc = iv[2] && ir[2];
         if (acc) begin
            sb.push_back(ref17(opc[2], id[2][16:0]));
            sent++;
         end
         if (ov[2] && ordy[2]) begin
            if (sb.size() == 0) chk("rand_dup", 1, 0);
            else begin
               e = sb.pop_front();
               chk($sformatf("rand_beat%0d", recv), {oe[2], od_c}, e);
            end
            recv++;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (!iv[2] || acc) begin
            iv[2] = sent < 10000 && $urandom_range(0, 1) == 1;
            opc[2] = 3'($urandom_range(0, 7));
            id[2] = $urandom;
         end
         ordy[2] = $urandom_range(0, 1) == 1;
         #1;
      end
      chk("rand_received", recv, 10000);
      chk("rand_leftover", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/reduce_pipe.md
REDUCE_PIPE -- requirements
Module: reduce_pipe

Interface
REQ-001 Parameter INPUT_WIDTH, default 8, bits reduced per channel; legal range 1..256.
REQ-002 Parameter CHANNELS, default 1, independent reduction lanes sharing one handshake and one op.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, reset: asynchronous assert, active-low.
REQ-005 Port in_valid, input, 1, input beat present.
REQ-006 Port in_ready, output, 1, block accepts a beat this cycle.
REQ-007 Port in_op, input, 3, operation: bit2 = invert result; bits[1:0] 00 AND, 01 OR, 10 XOR, 11 reserved.
REQ-008 Port in_data, input, CHANNELS*INPUT_WIDTH, lane c occupies bits [c*INPUT_WIDTH +: INPUT_WIDTH].
REQ-009 Port out_valid, output, 1, result beat present.
REQ-010 Port out_ready, input, 1, downstream accepts the result.
REQ-011 Port out_data, output, CHANNELS, one reduced bit per lane.
REQ-012 Port out_err, output, 1, result beat carried a reserved op.

Function
REQ-013 A beat SHALL transfer on input when in_valid and in_ready are both 1, and on output when out_valid and out_ready are both 1.
REQ-014 Reduction SHALL be a radix-4 tree with one register stage per level; LAT = max(1, ceil(log4(INPUT_WIDTH))) stages.
REQ-015 With out_ready held at 1, a beat accepted in cycle N SHALL appear on out_valid/out_data in cycle N+LAT.
REQ-016 Unused leaf positions SHALL be padded with the identity element: 1 for AND, 0 for OR and XOR.
REQ-017 Inversion (bit2) SHALL be applied once, in the final stage; NAND, NOR and XNOR are therefore op codes 100, 101 and 110.
REQ-018 in_op SHALL be captured with the data and travel with the beat; changing in_op between beats SHALL affect only later beats.
REQ-019 Reserved op (x11) SHALL produce out_data all-zero and out_err = 1 for that beat only; out_err SHALL be 0 on all other beats.
REQ-020 Each stage SHALL hold its content when it is valid and the next stage cannot accept; stage k ready = !valid_k || ready_{k+1}.
REQ-021 in_ready SHALL equal stage-0 ready, with no combinational path from in_valid to in_ready.
REQ-022 Full pipeline with out_ready = 0 SHALL hold LAT beats; no beat may be dropped or duplicated.
REQ-023 Simultaneous input and output transfers on a full pipeline SHALL sustain one beat per cycle.
REQ-024 INPUT_WIDTH = 1 SHALL give LAT = 1 and out_data = in_data XOR in_op[2], for non-reserved ops.
REQ-025 out_data and out_err SHALL remain stable while out_valid = 1 and out_ready = 0.

Reset
REQ-026 While rst_n = 0: out_valid = 0, out_data = 0, out_err = 0, all stage valid bits = 0, in_ready = 0.
REQ-027 in_ready SHALL rise in the first clock cycle after rst_n deasserts.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight beats; no stale beat may emerge after release.

Structure
REQ-029 Package reduce_pkg SHALL hold the op encodings, the identity-element function and the ceil-log4 function used for LAT.
REQ-030 One sub-module, reduce_stage, SHALL implement one radix-4 level with its valid/ready register slice; reduce_pipe SHALL instantiate it LAT times via generate.
REQ-031 Width, depth and lane count SHALL follow from the parameters alone; no hard-coded sizes.

Verification
REQ-032 INPUT_WIDTH=8, CHANNELS=2, op=101 (NOR), data 0x00_01, out_ready=1 -> after 2 cycles out_data=2'b10, out_err=0.
REQ-033 INPUT_WIDTH=5, op=000 (AND), data 5'b11111, then op=110 (XNOR), data 5'b10110 -> padding correct, outputs 1 then 0, back-to-back.
REQ-034 Three beats in, out_ready=0 for 6 cycles, then 1 -> in_ready drops after LAT beats; all beats emerge in order, unchanged.
REQ-035 op=011 beat between two OR beats -> middle beat out_data=0, out_err=1; neighbouring beats correct with out_err=0.
REQ-036 rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately; in_ready=1 one cycle after release; no old beat appears.
REQ-037 Random in_valid and out_ready at 50% each, 10k beats, INPUT_WIDTH=17 -> scoreboard matches a reference reduction, with no loss or duplication.
